// File: rtl/aes_pkg.sv
// Shared types, FIPS-197 S-box tables and the pass-count helper for the
// SubBytes engine. Optional build macro used by the engine: AES_SUBBYTES_PIPE_EN.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Number of substitution passes needed to cover one block.
  function automatic int unsigned pass_count(input int unsigned lanes,
                                             input int unsigned block_bytes);
    return block_bytes / lanes;
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One S-box lane: forward/inverse byte substitution selected by inv.
// With AES_SUBBYTES_PIPE_EN defined the lookup result is registered
// (cleared by reset and flush); otherwise the lane is purely combinational.
module aes_sbox_lane
  import aes_pkg::*;
(
`ifdef AES_SUBBYTES_PIPE_EN
  input  logic  clk,
  input  logic  reset_n,
  input  logic  flush,
`endif
  input  byte_t byte_in,
  input  logic  inv,
  output byte_t byte_out
);

  byte_t lookup_s;

  // Table lookup for the selected direction.
  always_comb begin
    if (inv) begin
      lookup_s = SBOX_INV[byte_in];
    end else begin
      lookup_s = SBOX_FWD[byte_in];
    end
  end

`ifdef AES_SUBBYTES_PIPE_EN
  byte_t byte_q;
  byte_t byte_d;

  // Next pipe value; a flush empties the pipe.
  always_comb begin
    if (flush) begin
      byte_d = 8'h00;
    end else begin
      byte_d = lookup_s;
    end
  end

  // Pipe register between lookup and write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_q <= 8'h00;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign byte_out = byte_q;
`else
  assign byte_out = lookup_s;
`endif

endmodule

// File: rtl/aes_subbytes_engine.sv
// Sequential SubBytes engine: accepts a BLOCK_BYTES state, substitutes LANES
// bytes per cycle (lowest indices first) and returns the result over a
// valid/ready handshake. Optional build macro AES_SUBBYTES_PIPE_EN registers
// each lane's lookup, adding one cycle of latency with identical results.
module aes_subbytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES       = 1,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     inv_mode,
  input  logic [8*BLOCK_BYTES-1:0] data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] data_out,
  output logic                     busy
);

  localparam int unsigned N     = pass_count(LANES, BLOCK_BYTES);
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'(N - 1);

  if (((LANES != 1) && (LANES != 2) && (LANES != 4) && (LANES != 8) && (LANES != 16)) ||
      ((BLOCK_BYTES % LANES) != 0)) begin : g_param_err
    $error("aes_subbytes_engine: LANES must be 1,2,4,8,16 and divide BLOCK_BYTES");
  end

  // State viewed as N passes of LANES bytes: byte index = pass*LANES + lane.
  state_e                          state_q, state_d;
  logic [N-1:0][LANES-1:0][7:0]    blk_q, blk_d;
  logic                            mode_q, mode_d;
  cnt_t                            cnt_q, cnt_d;
  logic                            out_valid_q, out_valid_d;
  logic                            busy_q, busy_d;
  logic                            in_ready_s;
  logic                            load_s;
  logic [LANES-1:0][7:0]           lane_in_s;
  logic [LANES-1:0][7:0]           lane_out_s;
`ifdef AES_SUBBYTES_PIPE_EN
  logic                            drain_q, drain_d;
  logic                            pvld_q, pvld_d;
  cnt_t                            wr_cnt_q, wr_cnt_d;
`endif

  // Handshake acceptance; a result being consumed frees the engine at once.
  always_comb begin
    if (state_q == IDLE) begin
      in_ready_s = 1'b1;
    end else if (state_q == DONE) begin
      in_ready_s = out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
    load_s    = in_valid & in_ready_s & ~flush;
    lane_in_s = blk_q[cnt_q];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lane u_lane (
`ifdef AES_SUBBYTES_PIPE_EN
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
`endif
      .byte_in  (lane_in_s[l]),
      .inv      (mode_q),
      .byte_out (lane_out_s[l])
    );
  end

  // Next-state logic: flush dominates, then the FSM, then a new load.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef AES_SUBBYTES_PIPE_EN
    drain_d     = drain_q;
    pvld_d      = pvld_q;
    wr_cnt_d    = wr_cnt_q;
`endif
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = '0;
`ifdef AES_SUBBYTES_PIPE_EN
      drain_d     = 1'b0;
      pvld_d      = 1'b0;
      wr_cnt_d    = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        BUSY: begin
`ifdef AES_SUBBYTES_PIPE_EN
          // Write-back trails the lookup by one pass; drain_q marks the final write.
          if (pvld_q) begin
            blk_d[wr_cnt_q] = lane_out_s;
          end else begin
            blk_d = blk_q;
          end
          wr_cnt_d = cnt_q;
          if (drain_q) begin
            drain_d     = 1'b0;
            pvld_d      = 1'b0;
            state_d     = DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end else if (cnt_q == LAST_CNT) begin
            drain_d = 1'b1;
            pvld_d  = 1'b1;
          end else begin
            pvld_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
`else
          blk_d[cnt_q] = lane_out_s;
          if (cnt_q == LAST_CNT) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
      if (load_s) begin
        state_d     = BUSY;
        blk_d       = data_in;
        mode_d      = inv_mode;
        cnt_d       = '0;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
`ifdef AES_SUBBYTES_PIPE_EN
        drain_d     = 1'b0;
        pvld_d      = 1'b0;
        wr_cnt_d    = '0;
`endif
      end else begin
        mode_d = mode_d;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_SUBBYTES_PIPE_EN
      drain_q     <= 1'b0;
      pvld_q      <= 1'b0;
      wr_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef AES_SUBBYTES_PIPE_EN
      drain_q     <= drain_d;
      pvld_q      <= pvld_d;
      wr_cnt_q    <= wr_cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = blk_q;

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Scoreboard bench for aes_subbytes_engine: four instances with different
// LANES/BLOCK_BYTES share one clock; stimulus pushes expected results, a
// negedge monitor pops and compares data and latency.
module tb_aes_subbytes_engine;

`ifdef AES_SUBBYTES_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  localparam int unsigned LN_T [4] = '{1, 16, 4, 2};
  localparam int unsigned BB_T [4] = '{16, 16, 16, 4};
  localparam int          LAT_T [4] = '{16 + PIPE, 1 + PIPE, 4 + PIPE, 2 + PIPE};

  localparam logic [127:0] VIN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] VOUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fl  [4];
  logic         iv  [4];
  logic         ir  [4];
  logic         im  [4];
  logic [127:0] din [4];
  logic         ov  [4];
  logic         orr [4];
  logic [127:0] dout[4];
  logic         bz  [4];

  item_t exp_q [4][$];
  logic  pres [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned LN  = LN_T[g];
    localparam int unsigned BBV = BB_T[g];
    logic [8*BBV-1:0] d_i;
    logic [8*BBV-1:0] d_o;
    assign d_i     = din[g][8*BBV-1:0];
    assign dout[g] = 128'(d_o);
    aes_subbytes_engine #(.LANES(LN), .BLOCK_BYTES(BBV)) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .flush     (fl[g]),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .inv_mode  (im[g]),
      .data_in   (d_i),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .data_out  (d_o),
      .busy      (bz[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare presented results against the head of each queue.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (ov[g] === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out dut%0d actual=%h required=none", g, dout[g]);
        end else begin
          chk($sformatf("dut%0d_data", g), dout[g], exp_q[g][0].data);
          if (!pres[g]) begin
            chk($sformatf("dut%0d_latency", g), 128'(cyc - exp_q[g][0].acc), 128'(LAT_T[g]));
            pres[g] = 1'b1;
          end
          if (orr[g]) begin
            void'(exp_q[g].pop_front());
            pres[g] = 1'b0;
          end
        end
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input int g, input logic [127:0] d, input logic m, input logic [127:0] e);
    bit done = 1'b0;
    din[g] = d;
    im[g]  = m;
    iv[g]  = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (ir[g]) begin
        exp_q[g].push_back('{e, cyc + 1});
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
    im[g] = ~m;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d actual=no_accept required=accept", g);
    end
  endtask

  task automatic wait_empty(input int g);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (exp_q[g].size() == 0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout dut%0d actual=%0d required=0", g, exp_q[g].size());
    end
  endtask

  task automatic wait_ov(input int g);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (ov[g]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout dut%0d actual=0 required=1", g);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      fl[g] = 1'b0; iv[g] = 1'b0; im[g] = 1'b0; din[g] = 128'd0; orr[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_out_valid%0d", g), 128'(ov[g]), 128'd0);
      chk($sformatf("rst_busy%0d", g), 128'(bz[g]), 128'd0);
      chk($sformatf("rst_data_out%0d", g), dout[g], 128'd0);
      chk($sformatf("rst_in_ready%0d", g), 128'(ir[g]), 128'd1);
    end
    @(posedge clk);
    #1;

    // FIPS-197 vector on LANES=1, 16, 4
    send(0, VIN, 1'b0, VOUT); wait_empty(0);
    send(1, VIN, 1'b0, VOUT); wait_empty(1);
    send(2, VIN, 1'b0, VOUT); wait_empty(2);

    // Inverse round trips and single-byte inverse values
    send(0, VOUT, 1'b1, VIN); wait_empty(0);
    send(1, VOUT, 1'b1, VIN); wait_empty(1);
    send(3, 128'h0000ed63, 1'b1, 128'h52525300); wait_empty(3);

    // Backpressure, then back-to-back accept on the consuming edge
    orr[0] = 1'b0;
    send(0, VIN, 1'b0, VOUT);
    wait_ov(0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(ir[0]), 128'd0);
      chk("bp_out_valid", 128'(ov[0]), 128'd1);
    end
    @(posedge clk);
    #1;
    orr[0] = 1'b1;
    send(0, 128'd0, 1'b0, {16{8'h63}});
    wait_empty(0);

    // Flush at cnt=7
    send(0, VIN, 1'b0, VOUT);
    repeat (7) @(posedge clk);
    #1 fl[0] = 1'b1;
    @(posedge clk);
    #1 fl[0] = 1'b0;
    exp_q[0].delete();
    @(negedge clk);
    chk("flush_out_valid", 128'(ov[0]), 128'd0);
    chk("flush_busy", 128'(bz[0]), 128'd0);
    chk("flush_in_ready", 128'(ir[0]), 128'd1);
    repeat (20) @(posedge clk);
    #1;
    send(0, VOUT, 1'b1, VIN); wait_empty(0);

    // Asynchronous reset mid-BUSY
    send(0, VIN, 1'b0, VOUT);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q[0].delete();
    #1;
    chk("arst_out_valid", 128'(ov[0]), 128'd0);
    chk("arst_busy", 128'(bz[0]), 128'd0);
    chk("arst_data_out", dout[0], 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(3, 128'd0, 1'b0, 128'h63636363); wait_empty(3);

    for (int g = 0; g < 4; g++) begin
      chk($sformatf("end_queue%0d", g), 128'(exp_q[g].size()), 128'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
